// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared sizes, owner-state type and address check for the data-memory arbiter
package dmem_arbiter_pkg;
   localparam int WORD_SIZE    = 32;
   localparam int IDX_BITS     = 8;
   localparam int DEF_MAX_HOLD = 4;
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_e;
   function automatic logic addr_err(input logic [WORD_SIZE-1:0] addr);
      return (addr[1:0] != 2'b00) || ((addr >> (IDX_BITS + 2)) != '0);
   endfunction
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two requester ports plus the single-port memory pins
interface dmem_arbiter_if;
   import dmem_arbiter_pkg::*;
   logic                 req0, req1, we0, we1, lock0, lock1;
   logic [WORD_SIZE-1:0] addr0, addr1, wdata0, wdata1;
   logic                 gnt0, gnt1, rvalid0, rvalid1, err0, err1;
   logic [WORD_SIZE-1:0] rdata0, rdata1;
   logic [WORD_SIZE-1:0] mem_address, mem_write_data, mem_read_data;
   logic                 mem_write, mem_read;
   modport slave (
      input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_read_data,
      output gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1,
      output mem_address, mem_write_data, mem_write, mem_read
   );
   modport master (
      output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_read_data,
      input  gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1,
      input  mem_address, mem_write_data, mem_write, mem_read
   );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker; on a tie the port that was not granted last wins
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);
   // A lone requester always wins; a tie goes away from the last winner
   always_comb begin
      gnt[0] = req[0] & (~req[1] | last);
      gnt[1] = req[1] & (~req[0] | ~last);
   end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin/lockable sharing of the single-port data memory between two requesters
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);
   localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

   owner_e               state_q, state_d;
   logic                 last_q, last_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic                 rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic                 err0_q, err0_d, err1_q, err1_d;
   logic [WORD_SIZE-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [1:0]           rr_gnt, gnt;
   logic                 keep0, keep1, sel1, we, lock, bad, ok;
   logic [WORD_SIZE-1:0] addr, wdata, rd_val;

   rr_pick2 u_pick (
      .req  ({bus.req1, bus.req0}),
      .last (last_q),
      .gnt  (rr_gnt)
   );

   // Pick the winner (lock first, then round-robin), mux its access and compute next state
   always_comb begin
      keep0     = (state_q == OWN0) && bus.req0 && bus.lock0 && (hold_q < HOLD_LIM || !bus.req1);
      keep1     = (state_q == OWN1) && bus.req1 && bus.lock1 && (hold_q < HOLD_LIM || !bus.req0);
      gnt       = reset ? 2'b00 : keep0 ? 2'b01 : keep1 ? 2'b10 : rr_gnt;
      sel1      = gnt[1];
      addr      = sel1 ? bus.addr1 : bus.addr0;
      wdata     = sel1 ? bus.wdata1 : bus.wdata0;
      we        = sel1 ? bus.we1 : bus.we0;
      lock      = sel1 ? bus.lock1 : bus.lock0;
      bad       = addr_err(addr);
      ok        = (gnt != 2'b00) && !bad;
      rd_val    = (ok && !we) ? bus.mem_read_data : '0;
      state_d   = (gnt == 2'b00 || !lock) ? IDLE : sel1 ? OWN1 : OWN0;
      last_d    = (gnt != 2'b00) ? sel1 : last_q;
      hold_d    = (state_d == IDLE) ? '0 : (state_d != state_q) ? HOLD_W'(1) :
                  (hold_q == HOLD_LIM) ? hold_q : hold_q + HOLD_W'(1);
      rvalid0_d = gnt[0];
      rvalid1_d = gnt[1];
      err0_d    = gnt[0] & bad;
      err1_d    = gnt[1] & bad;
      rdata0_d  = gnt[0] ? rd_val : rdata0_q;
      rdata1_d  = gnt[1] ? rd_val : rdata1_q;
   end

   // Owner FSM, round-robin pointer, hold counter and one-cycle response registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         hold_q    <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         hold_q    <= hold_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   assign bus.gnt0           = gnt[0];
   assign bus.gnt1           = gnt[1];
   assign bus.mem_address    = ok ? addr : '0;
   assign bus.mem_write_data = ok ? wdata : '0;
   assign bus.mem_write      = ok & we;
   assign bus.mem_read       = ok & ~we;
   assign bus.rvalid0        = rvalid0_q;
   assign bus.rvalid1        = rvalid1_q;
   assign bus.err0           = err0_q;
   assign bus.err1           = err1_q;
   assign bus.rdata0         = rdata0_q;
   assign bus.rdata1         = rdata1_q;
endmodule
